id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register plus execute-side operand selection for the pipelined MIPS core.
- Captures decode outputs each cycle and resolves RAW forwarding from MEM and WB.
- Detects load-use hazards and drives src_a_e, src_b_e and alu_control_opr straight into the ALU.
- Inserts bubbles on flush or load-use and holds on stall.

Parameters:
PC_BITS, 32, datapath width
REG_BITS, 5, register-index width
OPR_BITS, 4, ALU operation code width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
stall_e  input  1  hold EX register contents
flush_e  input  1  load bubble into EX register
rd1_d  input  PC_BITS  register-file read A value
rd2_d  input  PC_BITS  register-file read B value
sign_imm_d  input  PC_BITS  sign-extended immediate
rs_d  input  REG_BITS  rs index
rt_d  input  REG_BITS  rt index
rd_d  input  REG_BITS  rd index
alu_control_d  input  OPR_BITS  ALU opcode
alu_src_d  input  1  1 = immediate selected as B operand
reg_dst_d  input  1  1 = rd is destination, 0 = rt
reg_write_d  input  1  instruction writes register file
mem_to_reg_d  input  1  instruction is a load
mem_write_d  input  1  instruction is a store
alu_out_m  input  PC_BITS  MEM-stage ALU result
write_reg_m  input  REG_BITS  MEM destination index
reg_write_m  input  1  MEM stage writes
result_w  input  PC_BITS  WB-stage result
write_reg_w  input  REG_BITS  WB destination index
reg_write_w  input  1  WB stage writes
src_a_e  output  PC_BITS  ALU operand A
src_b_e  output  PC_BITS  ALU operand B
alu_control_opr  output  OPR_BITS  ALU opcode
write_data_e  output  PC_BITS  forwarded rt value for stores
write_reg_e  output  REG_BITS  selected destination index
reg_write_e  output  1  registered control
mem_to_reg_e  output  1  registered control
mem_write_e  output  1  registered control
lw_stall  output  1  load-use hazard; stall IF/ID
valid_e  output  1  EX slot holds a real instruction

Behaviour:
- One clock, clk; reset rst is asynchronous, active-high.
- Reset clears every register to 0.
  - Consequence: src_a_e = src_b_e = 0, alu_control_opr = 0, write_reg_e = 0, all control outputs = 0, valid_e = 0, lw_stall = 0.
  - Reset mid-operation discards the in-flight instruction immediately (asynchronously).
- Register update at each rising edge, priority order:
  - rst.
  - bubble when flush_e OR lw_stall: all fields 0, valid_e = 0.
  - hold when stall_e: all registers unchanged.
  - otherwise load the *_d inputs, valid_e = 1.
- Flush beats stall when both are asserted.
- lw_stall (combinational) = mem_to_reg_e AND valid_e AND rt_e != 0 AND (rt_e == rs_d OR rt_e == rt_d).
  - lw_stall auto-bubbles EX on the next edge.
- Forwarding (combinational), applied to A from rs_e and to B from rt_e:
  - if index != 0 AND reg_write_m AND write_reg_m == index: alu_out_m.
  - else if index != 0 AND reg_write_w AND write_reg_w == index: result_w.
  - else the registered rd1/rd2.
  - MEM has priority over WB.
  - Index 0 is never forwarded.
- write_data_e = forwarded B value before the immediate mux.
- src_b_e = alu_src_e ? sign_imm_e : write_data_e.
- write_reg_e = reg_dst_e ? rd_e : rt_e.
- Latency: 1 cycle from decode inputs to registered fields. Forward muxing is 0 cycles from MEM/WB inputs.
- No arithmetic is performed; all widths pass through unchanged.

Test Plan:
- rst high mid-stream -> all outputs 0 without waiting for a clock edge.
- After release, load rd1_d=5, rd2_d=7, alu_src_d=0, alu_control_d=ADD -> next cycle src_a_e=5, src_b_e=7, alu_control_opr=ADD, valid_e=1.
- Forwarding priority: rs_e=3, write_reg_m=3, reg_write_m=1, alu_out_m=0x11, write_reg_w=3, reg_write_w=1, result_w=0x22 -> src_a_e=0x11. Drop reg_write_m -> src_a_e=0x22. Set rs_e=0 with write_reg_m=0, reg_write_m=1 -> src_a_e equals registered rd1, not alu_out_m.
- Load-use: EX holds load with rt_e=8; decode rs_d=8 -> lw_stall=1; next edge valid_e=0, reg_write_e=0. Same setup with rt_e=0 -> lw_stall=0.
- stall_e=1 for 3 cycles with changing *_d inputs -> outputs constant. stall_e=1 with flush_e=1 -> bubble.
- Store: alu_src_d=1, sign_imm_d=0xFFFFFFFC, rt forwarded from WB with result_w=0xAB -> src_b_e=0xFFFFFFFC, write_data_e=0xAB.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Drives the execute-stage ALU operands, opcode and store data directly.

module id_ex_fwd_mux #(
  parameter int PC_BITS  = 32,
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_idx,
  input  logic [PC_BITS-1:0]  i_reg_val,
  input  logic                i_reg_write_m,
  input  logic [REG_BITS-1:0] i_write_reg_m,
  input  logic [PC_BITS-1:0]  i_alu_out_m,
  input  logic                i_reg_write_w,
  input  logic [REG_BITS-1:0] i_write_reg_w,
  input  logic [PC_BITS-1:0]  i_result_w,
  output logic [PC_BITS-1:0]  o_val
);
  logic w_nz;
  assign w_nz = (i_idx != '0);

  // MEM result is younger than WB, so it wins; $zero is never forwarded.
  always_comb begin
    o_val = i_reg_val;
    if (w_nz && i_reg_write_m && (i_write_reg_m == i_idx))
      o_val = i_alu_out_m;
    else if (w_nz && i_reg_write_w && (i_write_reg_w == i_idx))
      o_val = i_result_w;
  end
endmodule

module id_ex_operand_stage #(
  parameter int PC_BITS  = 32,
  parameter int REG_BITS = 5,
  parameter int OPR_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_e,
  input  logic                flush_e,
  input  logic [PC_BITS-1:0]  rd1_d,
  input  logic [PC_BITS-1:0]  rd2_d,
  input  logic [PC_BITS-1:0]  sign_imm_d,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic [REG_BITS-1:0] rd_d,
  input  logic [OPR_BITS-1:0] alu_control_d,
  input  logic                alu_src_d,
  input  logic                reg_dst_d,
  input  logic                reg_write_d,
  input  logic                mem_to_reg_d,
  input  logic                mem_write_d,
  input  logic [PC_BITS-1:0]  alu_out_m,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic                reg_write_m,
  input  logic [PC_BITS-1:0]  result_w,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_w,
  output logic [PC_BITS-1:0]  src_a_e,
  output logic [PC_BITS-1:0]  src_b_e,
  output logic [OPR_BITS-1:0] alu_control_opr,
  output logic [PC_BITS-1:0]  write_data_e,
  output logic [REG_BITS-1:0] write_reg_e,
  output logic                reg_write_e,
  output logic                mem_to_reg_e,
  output logic                mem_write_e,
  output logic                lw_stall,
  output logic                valid_e
);
  typedef struct packed {
    logic [PC_BITS-1:0]  rd1;
    logic [PC_BITS-1:0]  rd2;
    logic [PC_BITS-1:0]  imm;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] rd;
    logic [OPR_BITS-1:0] alu_ctl;
    logic                alu_src;
    logic                reg_dst;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_write;
    logic                valid;
  } ex_reg_t;

  ex_reg_t             r_ex;
  ex_reg_t             w_ex_d;
  logic [PC_BITS-1:0]  w_fwd_a;
  logic [PC_BITS-1:0]  w_fwd_b;

  always_comb begin
    w_ex_d            = '0;
    w_ex_d.rd1        = rd1_d;
    w_ex_d.rd2        = rd2_d;
    w_ex_d.imm        = sign_imm_d;
    w_ex_d.rs         = rs_d;
    w_ex_d.rt         = rt_d;
    w_ex_d.rd         = rd_d;
    w_ex_d.alu_ctl    = alu_control_d;
    w_ex_d.alu_src    = alu_src_d;
    w_ex_d.reg_dst    = reg_dst_d;
    w_ex_d.reg_write  = reg_write_d;
    w_ex_d.mem_to_reg = mem_to_reg_d;
    w_ex_d.mem_write  = mem_write_d;
    w_ex_d.valid      = 1'b1;
  end

  // Bubble (flush or load-use) outranks hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_ex <= '0;
    else if (flush_e || lw_stall) r_ex <= '0;
    else if (!stall_e)            r_ex <= w_ex_d;
  end

  assign lw_stall = r_ex.mem_to_reg && r_ex.valid && (r_ex.rt != '0) &&
                    ((r_ex.rt == rs_d) || (r_ex.rt == rt_d));

  id_ex_fwd_mux #(.PC_BITS(PC_BITS), .REG_BITS(REG_BITS)) u_fwd_a (
    .i_idx(r_ex.rs), .i_reg_val(r_ex.rd1),
    .i_reg_write_m(reg_write_m), .i_write_reg_m(write_reg_m), .i_alu_out_m(alu_out_m),
    .i_reg_write_w(reg_write_w), .i_write_reg_w(write_reg_w), .i_result_w(result_w),
    .o_val(w_fwd_a)
  );

  id_ex_fwd_mux #(.PC_BITS(PC_BITS), .REG_BITS(REG_BITS)) u_fwd_b (
    .i_idx(r_ex.rt), .i_reg_val(r_ex.rd2),
    .i_reg_write_m(reg_write_m), .i_write_reg_m(write_reg_m), .i_alu_out_m(alu_out_m),
    .i_reg_write_w(reg_write_w), .i_write_reg_w(write_reg_w), .i_result_w(result_w),
    .o_val(w_fwd_b)
  );

  assign src_a_e         = w_fwd_a;
  assign write_data_e    = w_fwd_b;
  assign src_b_e         = r_ex.alu_src ? r_ex.imm : w_fwd_b;
  assign alu_control_opr = r_ex.alu_ctl;
  assign write_reg_e     = r_ex.reg_dst ? r_ex.rd : r_ex.rt;
  assign reg_write_e     = r_ex.reg_write;
  assign mem_to_reg_e    = r_ex.mem_to_reg;
  assign mem_write_e     = r_ex.mem_write;
  assign valid_e         = r_ex.valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected output snapshots queued at
// stimulus time and compared against the DUT after the clock edge.

module tb_id_ex_operand_stage;
  logic        clk, rst, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, sign_imm_d, alu_out_m, result_w;
  logic [4:0]  rs_d, rt_d, rd_d, write_reg_m, write_reg_w;
  logic [3:0]  alu_control_d;
  logic        alu_src_d, reg_dst_d, reg_write_d, mem_to_reg_d, mem_write_d;
  logic        reg_write_m, reg_write_w;
  logic [31:0] src_a_e, src_b_e, write_data_e;
  logic [3:0]  alu_control_opr;
  logic [4:0]  write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, lw_stall, valid_e;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
    .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .reg_write_d(reg_write_d),
    .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .alu_out_m(alu_out_m), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .result_w(result_w), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_opr(alu_control_opr),
    .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mem_write_e(mem_write_e), .lw_stall(lw_stall), .valid_e(valid_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, m2r, mw, v, lw;
  } obs_t;

  obs_t q[$];
  obs_t obs, e;
  int   checks = 0;
  int   failures = 0;
  localparam logic [3:0] ADD = 4'b0010;

  function automatic obs_t mk(input logic [31:0] a, b, input logic [3:0] alu,
                              input logic [31:0] wd, input logic [4:0] wr,
                              input logic rw, m2r, mw, v, lw);
    mk = '{a, b, alu, wd, wr, rw, m2r, mw, v, lw};
  endfunction

  function automatic obs_t get_obs();
    get_obs = '{src_a_e, src_b_e, alu_control_opr, write_data_e, write_reg_e,
                reg_write_e, mem_to_reg_e, mem_write_e, valid_e, lw_stall};
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 0 && reg_write_m && write_reg_m == idx) return alu_out_m;
    if (idx != 0 && reg_write_w && write_reg_w == idx) return result_w;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    stall_e = 0; flush_e = 0;
    rd1_d = 0; rd2_d = 0; sign_imm_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    alu_control_d = 0; alu_src_d = 0; reg_dst_d = 0; reg_write_d = 0;
    mem_to_reg_d = 0; mem_write_d = 0;
    alu_out_m = 0; write_reg_m = 0; reg_write_m = 0;
    result_w = 0; write_reg_w = 0; reg_write_w = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_in();
    q.push_back('0);
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs, e); end
    rst = 0;
    rd1_d = 32'h1234; rd2_d = 32'h5678; alu_control_d = ADD; reg_write_d = 1; rt_d = 6;
    tick();
    checks++;
    if (valid_e !== 1'b1) begin failures++; $display("FAIL reset_preload got=%b exp=1", valid_e); end
    #2 rst = 1;
    q.push_back('0);
    #1;
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
    tick();
    rst = 0; clear_in();
  endtask

  task automatic test_basic();
    clear_in();
    rd1_d = 5; rd2_d = 7; alu_control_d = ADD; rs_d = 1; rt_d = 2; rd_d = 3;
    reg_dst_d = 1; reg_write_d = 1;
    q.push_back(mk(5, 7, ADD, 7, 3, 1, 0, 0, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL basic_add got=%h exp=%h", obs, e); end
  endtask

  task automatic test_forward();
    clear_in();
    rs_d = 3; rt_d = 4; rd1_d = 32'h55; rd2_d = 32'h66; alu_control_d = ADD; reg_write_d = 1;
    write_reg_m = 3; reg_write_m = 1; alu_out_m = 32'h11;
    write_reg_w = 3; reg_write_w = 1; result_w = 32'h22;
    q.push_back(mk(32'h11, 32'h66, ADD, 32'h66, 4, 1, 0, 0, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_mem_prio got=%h exp=%h", obs, e); end
    reg_write_m = 0;
    q.push_back(mk(32'h22, 32'h66, ADD, 32'h66, 4, 1, 0, 0, 1, 0));
    #1;
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_wb got=%h exp=%h", obs, e); end
    write_reg_m = 4; reg_write_m = 1;
    q.push_back(mk(32'h22, 32'h11, ADD, 32'h11, 4, 1, 0, 0, 1, 0));
    #1;
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_b_mem got=%h exp=%h", obs, e); end
    rs_d = 0; rd1_d = 32'h99;
    write_reg_m = 0; reg_write_m = 1; write_reg_w = 0; reg_write_w = 1;
    q.push_back(mk(32'h99, 32'h66, ADD, 32'h66, 4, 1, 0, 0, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_zero_idx got=%h exp=%h", obs, e); end
  endtask

  task automatic test_load_use();
    clear_in();
    rs_d = 1; rt_d = 8; rd1_d = 32'h10; sign_imm_d = 4; alu_src_d = 1;
    alu_control_d = ADD; mem_to_reg_d = 1; reg_write_d = 1;
    tick();
    mem_to_reg_d = 0; alu_src_d = 0; sign_imm_d = 0;
    rs_d = 8; rt_d = 2; rd_d = 5; reg_dst_d = 1; rd1_d = 3; rd2_d = 4;
    q.push_back(mk(32'h10, 4, ADD, 0, 8, 1, 1, 0, 1, 1));
    #1;
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lw_detect got=%h exp=%h", obs, e); end
    q.push_back('0);
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lw_bubble got=%h exp=%h", obs, e); end
    q.push_back(mk(3, 4, ADD, 4, 5, 1, 0, 0, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lw_resume got=%h exp=%h", obs, e); end
    clear_in();
    rs_d = 1; rt_d = 0; rd1_d = 32'h10; sign_imm_d = 4; alu_src_d = 1;
    alu_control_d = ADD; mem_to_reg_d = 1; reg_write_d = 1;
    tick();
    rs_d = 0; rt_d = 0;
    q.push_back(mk(32'h10, 4, ADD, 0, 0, 1, 1, 0, 1, 0));
    #1;
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL lw_rt_zero got=%h exp=%h", obs, e); end
  endtask

  task automatic test_stall();
    clear_in();
    rd1_d = 32'hA1; rd2_d = 32'hA2; rs_d = 1; rt_d = 2; rd_d = 3;
    reg_dst_d = 1; reg_write_d = 1; alu_control_d = 4'h5;
    q.push_back(mk(32'hA1, 32'hA2, 4'h5, 32'hA2, 3, 1, 0, 0, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL stall_load got=%h exp=%h", obs, e); end
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rd1_d = $urandom; rd2_d = $urandom; rd_d = 5'(i + 10); alu_control_d = 4'(i + 7);
      mem_write_d = 1;
      q.push_back(mk(32'hA1, 32'hA2, 4'h5, 32'hA2, 3, 1, 0, 0, 1, 0));
      tick();
      obs = get_obs(); e = q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, e); end
    end
    flush_e = 1;
    q.push_back('0);
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL stall_flush got=%h exp=%h", obs, e); end
    clear_in();
  endtask

  task automatic test_store();
    clear_in();
    alu_src_d = 1; sign_imm_d = 32'hFFFF_FFFC; rs_d = 1; rt_d = 9;
    rd1_d = 32'h100; rd2_d = 1; mem_write_d = 1; alu_control_d = ADD;
    write_reg_w = 9; reg_write_w = 1; result_w = 32'hAB;
    q.push_back(mk(32'h100, 32'hFFFF_FFFC, ADD, 32'hAB, 9, 0, 0, 1, 1, 0));
    tick();
    obs = get_obs(); e = q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL store got=%h exp=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    clear_in();
    for (int i = 0; i < 24; i++) begin
      rd1_d = $urandom; rd2_d = $urandom; sign_imm_d = $urandom;
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rd_d = 5'($urandom); alu_control_d = 4'($urandom);
      alu_src_d = 1'($urandom); reg_dst_d = 1'($urandom);
      reg_write_d = 1'($urandom); mem_write_d = 1'($urandom); mem_to_reg_d = 0;
      alu_out_m = $urandom; write_reg_m = 5'($urandom_range(0, 3)); reg_write_m = 1'($urandom);
      result_w = $urandom; write_reg_w = 5'($urandom_range(0, 3)); reg_write_w = 1'($urandom);
      q.push_back(mk(fwd(rs_d, rd1_d),
                     alu_src_d ? sign_imm_d : fwd(rt_d, rd2_d),
                     alu_control_d, fwd(rt_d, rd2_d),
                     reg_dst_d ? rd_d : rt_d,
                     reg_write_d, 1'b0, mem_write_d, 1'b1, 1'b0));
      tick();
      obs = get_obs(); e = q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_stall();
    test_store();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
